poly1305_mac: RTL and testbench
===============================

POLY1305_MAC -- requirements
Module: poly1305_mac

Interface
REQ-001 The block SHALL have these ports, in this order:
  clock  in  1  single clock, rising edge
  clear  in  1  synchronous, active-high reset
  start  in  1  begin a message; key sampled on the same cycle
  key  in  256  one-time key; r = key[127:0], s = key[255:128]; little-endian byte order per RFC 8439
  data_valid  in  1  message block offered
  data  in  128  message block, little-endian; byte 0 = data[7:0]
  data_last  in  1  offered block is the final block
  data_bytes_minus_one  in  4  valid bytes in block minus one; 15 = full block
  data_ready  out  1  block accepted when data_valid & data_ready
  tag_valid  out  1  tag available
  tag  out  128  16-byte authenticator, little-endian
  tag_ready  in  1  consumer accepts the tag when tag_valid & tag_ready
  busy  out  1  high in every state except IDLE
REQ-002 Clock and reset SHALL be one clock, clock, and one synchronous active-high reset, clear.

Function
REQ-003 The FSM SHALL have four states: IDLE, ABSORB, FINALIZE, DONE.
REQ-004 IDLE: start=1 SHALL latch r_clamped = key[127:0] AND 0x0ffffffc0ffffffc0ffffffc0fffffff, latch s = key[255:128], set acc to 0, and move to ABSORB; start SHALL be ignored in all other states.
REQ-005 ABSORB: data_ready SHALL be 1; on each handshake acc SHALL take the poly1305_block result for (acc, masked data, data_bytes_minus_one, r_clamped); throughput SHALL be one block per cycle.
REQ-006 Bytes of data at index > data_bytes_minus_one SHALL be forced to zero before the block update.
REQ-007 data_bytes_minus_one < 15 without data_last SHALL be treated as if it were 15 (only the final block can be partial).
REQ-008 A handshake with data_last=1 SHALL update acc and move to FINALIZE on the next cycle; data_ready SHALL be 0 outside ABSORB.
REQ-009 FINALIZE (one cycle): acc_red = acc - p if acc >= p, else acc, where p = 2^130-5; tag register = (acc_red + s) mod 2^128; then move to DONE.
REQ-010 DONE: tag_valid SHALL be 1, with tag held stable; tag_valid & tag_ready SHALL return the FSM to IDLE on the next cycle; start in that same cycle SHALL be ignored.
REQ-011 Latency: the tag SHALL be valid 2 cycles after the last-block handshake cycle.
REQ-012 Every message SHALL contain at least one block; empty messages are out of scope.
REQ-013 data_valid=0 in ABSORB SHALL hold acc and state unchanged, with no timeout.

Reset
REQ-014 clear SHALL have priority over all other inputs, including mid-message; it SHALL force state to IDLE, acc, r_clamped, s and tag to 0, and drive data_ready=0, tag_valid=0, busy=0.
REQ-015 The first start after clear SHALL produce a correct tag, with no state carried over from the aborted message.

Structure
REQ-016 poly1305_pkg SHALL hold: P (130-bit), R_CLAMP_MASK (128-bit), the state enum, and the width constants (BLOCK_BITS=128, ACC_BITS=130, KEY_BITS=256).
REQ-017 The single sub-module SHALL be poly1305_block, used unchanged as the combinational datapath; the byte mask, final reduction and FSM SHALL be in poly1305_mac.
REQ-018 The registers SHALL be: state, acc[129:0], r_clamped[127:0], s[127:0], tag[127:0]; tag_valid and data_ready SHALL be decoded from state.

Verification
REQ-019 RFC 8439 2.5.2 vector: key 85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b; message "Cryptographic Forum Research Group" sent as 3 blocks (16, 16, 2 bytes; last block bytes_minus_one=1) -> tag a8061dc1305136c6c22b8baf0c0127a9.
REQ-020 key all-zero, one full block of 0x00 -> tag = 0; key r=0 with s=0x0f0e..00, any 2 blocks -> tag = s.
REQ-021 Garbage in the unused bytes of a 2-byte last block SHALL give the same tag as the RFC vector; the same block with data_last=0 SHALL be treated as a full 16-byte block.
REQ-022 Backpressure: data_valid toggled 1/0 in ABSORB and tag_ready held low for 5 cycles in DONE -> tag unchanged, tag_valid held, data_ready=0, RFC tag still correct.
REQ-023 clear asserted on the cycle after the second RFC block handshake -> next cycle busy=0, data_ready=0; a full rerun then gives the RFC tag; start pulsed during ABSORB and DONE -> no effect.

Source files
------------

// File: rtl/poly1305_pkg.sv
// Shared constants and state encoding for the Poly1305 MAC engine.
package poly1305_pkg;
   localparam int BLOCK_BITS = 128;
   localparam int ACC_BITS   = 130;
   localparam int KEY_BITS   = 256;

   // 2^130 - 5
   localparam logic [ACC_BITS-1:0]   P            = ~(130'd4);
   localparam logic [BLOCK_BITS-1:0] R_CLAMP_MASK = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

   typedef enum logic [1:0] {IDLE, ABSORB, FINALIZE, DONE} state_t;
endpackage

// File: rtl/poly1305_block.sv
// One Poly1305 block step: acc_next = ((acc + padded block) * r) mod (2^130 - 5), fully reduced.
module poly1305_block
   import poly1305_pkg::*;
(
   input  logic [ACC_BITS-1:0]   acc,
   input  logic [BLOCK_BITS-1:0] blk,
   input  logic [3:0]            bytes_minus_one,
   input  logic [127:0]          r,
   output logic [ACC_BITS-1:0]   acc_next
);
   logic [7:0]   shamt;
   logic [128:0] m;
   logic [130:0] h;
   logic [258:0] prod;
   logic [128:0] hi1;
   logic [132:0] f1;
   logic [130:0] f2;

   always_comb begin
      // 0x01 pad byte sits just above the last valid byte (bit 128 for a full block)
      shamt    = ({4'd0, bytes_minus_one} + 8'd1) << 3;
      m        = {1'b0, blk} | (129'd1 << shamt);
      h        = {1'b0, acc} + {2'b00, m};
      prod     = {128'd0, h} * {131'd0, r};
      // fold twice using 2^130 == 5 (mod p), then one conditional subtract
      hi1      = prod[258:130];
      f1       = {3'd0, prod[129:0]} + {4'd0, hi1} + ({4'd0, hi1} << 2);
      f2       = {1'b0, f1[129:0]} + {128'd0, f1[132:130]} * 131'd5;
      acc_next = f2[129:0] - ((f2 >= {1'b0, P}) ? P : '0);
   end
endmodule

// File: rtl/poly1305_mac.sv
// Streaming Poly1305 MAC: one 16-byte block per cycle, tag two cycles after the last block.
module poly1305_mac
   import poly1305_pkg::*;
(
   input  logic         clock,
   input  logic         clear,
   input  logic         start,
   input  logic [255:0] key,
   input  logic         data_valid,
   input  logic [127:0] data,
   input  logic         data_last,
   input  logic [3:0]   data_bytes_minus_one,
   output logic         data_ready,
   output logic         tag_valid,
   output logic [127:0] tag,
   input  logic         tag_ready,
   output logic         busy
);
   state_t        state;
   logic [129:0]  acc;
   logic [127:0]  r_clamped;
   logic [127:0]  s;

   logic [3:0]    eff_bm;
   logic [127:0]  blk_masked;
   logic [129:0]  acc_next;
   logic [127:0]  tag_next;

   // only the final block may be partial; zero the bytes beyond its length
   always_comb begin
      eff_bm     = data_last ? data_bytes_minus_one : 4'hf;
      blk_masked = '0;
      for (int i = 0; i < 16; i++)
         blk_masked[8*i +: 8] = (4'(i) <= eff_bm) ? data[8*i +: 8] : 8'h00;
   end

   poly1305_block u_block (
      .acc             (acc),
      .blk             (blk_masked),
      .bytes_minus_one (eff_bm),
      .r               (r_clamped),
      .acc_next        (acc_next)
   );

   // tag is computed mod 2^128, so only the low bits of the reduced acc matter
   assign tag_next = acc[127:0] - ((acc >= P) ? P[127:0] : 128'd0) + s;

   assign data_ready = (state == ABSORB);
   assign tag_valid  = (state == DONE);
   assign busy       = (state != IDLE);

   always_ff @(posedge clock) begin
      if (clear) begin
         state     <= IDLE;
         acc       <= '0;
         r_clamped <= '0;
         s         <= '0;
         tag       <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               r_clamped <= key[127:0] & R_CLAMP_MASK;
               s         <= key[255:128];
               acc       <= '0;
               state     <= ABSORB;
            end
            ABSORB: if (data_valid) begin
               acc <= acc_next;
               if (data_last) state <= FINALIZE;
            end
            FINALIZE: begin
               tag   <= tag_next;
               state <= DONE;
            end
            DONE: if (tag_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_poly1305_mac.sv
// Directed bench for poly1305_mac: RFC 8439 vector, padding/masking, reduction, backpressure, abort.
module tb_poly1305_mac;
   logic         clock = 1'b0;
   logic         clear;
   logic         start;
   logic [255:0] key;
   logic         data_valid;
   logic [127:0] data;
   logic         data_last;
   logic [3:0]   data_bytes_minus_one;
   logic         data_ready;
   logic         tag_valid;
   logic [127:0] tag;
   logic         tag_ready;
   logic         busy;

   int checks = 0;
   int errs   = 0;

   logic [255:0] rfc_key;
   logic [127:0] rfc_b1, rfc_b2, rfc_b3, rfc_tag, garb_b3, str;

   poly1305_mac dut (
      .clock                (clock),
      .clear                (clear),
      .start                (start),
      .key                  (key),
      .data_valid           (data_valid),
      .data                 (data),
      .data_last            (data_last),
      .data_bytes_minus_one (data_bytes_minus_one),
      .data_ready           (data_ready),
      .tag_valid            (tag_valid),
      .tag                  (tag),
      .tag_ready            (tag_ready),
      .busy                 (busy)
   );

   always #5 clock = ~clock;

   function automatic logic [127:0] sw128(input logic [127:0] x);
      logic [127:0] y;
      for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
      return y;
   endfunction

   function automatic logic [255:0] sw256(input logic [255:0] x);
      logic [255:0] y;
      for (int i = 0; i < 32; i++) y[8*i +: 8] = x[8*(31-i) +: 8];
      return y;
   endfunction

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   // entered and left on a falling edge
   task automatic begin_msg(input logic [255:0] k);
      key   = k;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("busy_absorb", {127'd0, busy}, 128'd1);
   endtask

   task automatic send(input logic [127:0] d, input logic [3:0] bm, input logic last);
      int n = 0;
      data_valid           = 1'b1;
      data                 = d;
      data_bytes_minus_one = bm;
      data_last            = last;
      while (!data_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("data_ready", {127'd0, data_ready}, 128'd1);
      @(negedge clock);
      data_valid = 1'b0;
      data_last  = 1'b0;
      data       = '0;
   endtask

   // called right after the last-block handshake; hold = cycles tag_ready stays low in DONE
   task automatic end_msg(input string nm, input logic [127:0] exp, input int hold);
      int n = 0;
      chk({nm, "_lat1"}, {127'd0, tag_valid}, 128'd0);
      @(negedge clock);
      chk({nm, "_lat2"}, {127'd0, tag_valid}, 128'd1);
      while (!tag_valid && n < 10) begin
         @(negedge clock);
         n++;
      end
      for (int h = 0; h < hold; h++) begin
         chk({nm, "_hold_tag"}, tag, exp);
         chk({nm, "_hold_tv"}, {127'd0, tag_valid}, 128'd1);
         chk({nm, "_hold_rdy"}, {127'd0, data_ready}, 128'd0);
         start = (h == 2);
         key   = '0;
         @(negedge clock);
      end
      chk({nm, "_tag"}, tag, exp);
      tag_ready = 1'b1;
      start     = 1'b1;
      @(negedge clock);
      tag_ready = 1'b0;
      start     = 1'b0;
      chk({nm, "_idle"}, {127'd0, busy}, 128'd0);
   endtask

   task automatic rfc_run(input string nm);
      begin_msg(rfc_key);
      send(rfc_b1, 4'hf, 1'b0);
      send(rfc_b2, 4'hf, 1'b0);
      send(rfc_b3, 4'h1, 1'b1);
      end_msg(nm, rfc_tag, 0);
   endtask

   initial begin
      rfc_key = sw256(256'h85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b);
      rfc_tag = sw128(128'ha8061dc1305136c6c22b8baf0c0127a9);
      str     = "Cryptographic Fo";
      rfc_b1  = sw128(str);
      str     = "rum Research Gro";
      rfc_b2  = sw128(str);
      rfc_b3  = 128'h7075;
      garb_b3 = 128'hdeadbeef_cafebabe_01234567_89ab7075;

      clear = 1'b1; start = 1'b0; key = '0; data_valid = 1'b0; data = '0;
      data_last = 1'b0; data_bytes_minus_one = 4'h0; tag_ready = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_ready", {127'd0, data_ready}, 128'd0);
      chk("rst_tv", {127'd0, tag_valid}, 128'd0);
      chk("rst_tag", tag, 128'd0);
      clear = 1'b0;
      @(negedge clock);

      rfc_run("rfc");

      // garbage tail, start during ABSORB, idle gap, tag held off for 5 cycles
      begin_msg(rfc_key);
      start = 1'b1;
      key   = '0;
      send(rfc_b1, 4'hf, 1'b0);
      start = 1'b0;
      chk("gap_ready", {127'd0, data_ready}, 128'd1);
      @(negedge clock);
      send(rfc_b2, 4'hf, 1'b0);
      @(negedge clock);
      send(garb_b3, 4'h1, 1'b1);
      end_msg("bp", rfc_tag, 5);

      begin_msg(256'd0);
      send(128'd0, 4'hf, 1'b1);
      end_msg("zero", 128'd0, 0);

      // r clamps to zero, so the tag is s regardless of the data
      begin_msg({128'h0f0e0d0c0b0a09080706050403020100, 128'hf0000003_f0000003_f0000003_f0000000});
      send(128'h1234, 4'hf, 1'b0);
      send(128'hffff_0000_5555, 4'h7, 1'b1);
      end_msg("r0", 128'h0f0e0d0c0b0a09080706050403020100, 0);

      // r = 1: tag is the plain sum of padded blocks
      begin_msg({128'd0, 128'd1});
      send(garb_b3, 4'h1, 1'b0);
      send(128'd0, 4'h0, 1'b1);
      end_msg("nolast_full", 128'hdeadbeef_cafebabe_01234567_89ab7175, 0);

      begin_msg({128'd0, 128'd1});
      send(garb_b3, 4'h1, 1'b1);
      end_msg("partial", 128'h17075, 0);

      // (2^129-1)*2 = 2^130-2 == 3 mod p
      begin_msg({128'h10, 128'd1});
      send({128{1'b1}}, 4'hf, 1'b0);
      send({128{1'b1}}, 4'hf, 1'b1);
      end_msg("wrap", 128'h13, 0);

      // abort mid-message, then rerun
      begin_msg(rfc_key);
      send(rfc_b1, 4'hf, 1'b0);
      send(rfc_b2, 4'hf, 1'b0);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      chk("abort_busy", {127'd0, busy}, 128'd0);
      chk("abort_ready", {127'd0, data_ready}, 128'd0);
      chk("abort_tv", {127'd0, tag_valid}, 128'd0);
      rfc_run("rerun");

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end
endmodule
